// File: rtl/common.sv
// Shared bus types: ibus (fetch <-> icache) and cbus (cache <-> memory interconnect).
package common;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

    typedef logic [2:0] cbus_size_t;
    typedef logic [7:0] cbus_strobe_t;
    typedef logic [3:0] cbus_len_t;

    typedef struct packed {
        logic  valid;
        addr_t addr;
    } ibus_req_t;

    typedef struct packed {
        logic addr_ok;
        logic data_ok;
        u32   data;
    } ibus_resp_t;

    typedef struct packed {
        logic         valid;
        logic         is_write;
        cbus_size_t   size;
        addr_t        addr;
        cbus_strobe_t strobe;
        u64           data;
        cbus_len_t    len;
    } cbus_req_t;

    typedef struct packed {
        logic ready;
        logic last;
        u64   data;
    } cbus_resp_t;
endpackage

// File: rtl/pipes.sv
// Pipeline-side shared definitions: icache FSM states and cbus burst constants.
package pipes;
    import common::*;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        RESP
    } icache_state_t;

    localparam cbus_size_t CBUS_SIZE_8B = 3'b011;

    // cbus len encodes beats-1
    function automatic cbus_len_t cbus_burst_len(input int beats);
        return cbus_len_t'(beats - 1);
    endfunction
endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage of the direct-mapped icache: one read port, one beat write port,
// and a validate strobe that installs the tag and sets the valid bit.
module icache_array
    import common::*;
#(
    parameter int NUM_LINES  = 16,
    parameter int LINE_BEATS = 2,
    parameter int IDX_W      = $clog2(NUM_LINES),
    parameter int BEAT_W     = $clog2(LINE_BEATS),
    parameter int TAG_W      = 32 - 3 - BEAT_W - IDX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_index,
    input  logic [TAG_W-1:0]  rd_tag,
    input  logic [BEAT_W-1:0] rd_beat,
    input  logic              rd_half,
    output logic              hit,
    output u32                rd_word,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [BEAT_W-1:0] wr_beat,
    input  u64                wr_data,
    input  logic              validate,
    input  logic [TAG_W-1:0]  wr_tag
);
    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    u64                   data_mem [NUM_LINES*LINE_BEATS];
    u64                   rd_beat_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (validate) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[{wr_index, wr_beat}] <= wr_data;
        end
        if (validate) begin
            tag_mem[wr_index] <= wr_tag;
        end
    end

    assign rd_beat_data = data_mem[{rd_index, rd_beat}];
    assign rd_word      = rd_half ? rd_beat_data[63:32] : rd_beat_data[31:0];
    assign hit          = valid_q[rd_index] && (tag_mem[rd_index] == rd_tag);
endmodule

// File: rtl/icache_ibus_responder.sv
// Direct-mapped read-only icache answering ibus fetches; misses refill a full line by one cbus burst.
// Optional build macro ICACHE_PERF_EN adds hit/miss counters reported on a marker instruction.
module icache_ibus_responder
    import common::*;
    import pipes::*;
#(
    parameter int NUM_LINES  = 16,
    parameter int LINE_BEATS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    output cbus_req_t  creq,
    input  cbus_resp_t cresp
);
    localparam int BEAT_W = $clog2(LINE_BEATS);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int OFF_W  = 3 + BEAT_W;
    localparam int TAG_W  = 32 - OFF_W - IDX_W;

    // state  | meaning
    // IDLE   | waiting for a fetch; hit/miss lookup on ireq
    // REFILL | cbus burst filling the line of req_addr
    // RESP   | data_ok with the latched instruction
    icache_state_t     state;
    addr_t             req_addr;
    logic [BEAT_W-1:0] beat_cnt;
    u32                instr;

    addr_t lookup_addr;
    logic  hit;
    u32    rd_word;
    u32    refill_word;
    logic  wr_en;
    logic  validate;
    logic  same_req;
    logic  unused_addr_bits;

    // During refill the read port looks at the line being filled, so the
    // final instruction can be taken from beats already written.
    assign lookup_addr      = (state == REFILL) ? req_addr : ireq.addr;
    assign wr_en            = (state == REFILL) && cresp.ready;
    assign validate         = wr_en && cresp.last;
    assign same_req         = ireq.valid && (ireq.addr[31:2] == req_addr[31:2]);
    assign unused_addr_bits = ^{lookup_addr[1:0], req_addr[1:0]};

    always_comb begin
        refill_word = rd_word;
        if (req_addr[3 +: BEAT_W] == beat_cnt) begin
            refill_word = req_addr[2] ? cresp.data[63:32] : cresp.data[31:0];
        end
    end

    icache_array #(
        .NUM_LINES  (NUM_LINES),
        .LINE_BEATS (LINE_BEATS),
        .IDX_W      (IDX_W),
        .BEAT_W     (BEAT_W),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .rd_index (lookup_addr[OFF_W +: IDX_W]),
        .rd_tag   (lookup_addr[31 -: TAG_W]),
        .rd_beat  (lookup_addr[3 +: BEAT_W]),
        .rd_half  (lookup_addr[2]),
        .hit      (hit),
        .rd_word  (rd_word),
        .wr_en    (wr_en),
        .wr_index (req_addr[OFF_W +: IDX_W]),
        .wr_beat  (beat_cnt),
        .wr_data  (cresp.data),
        .validate (validate),
        .wr_tag   (req_addr[31 -: TAG_W])
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            req_addr <= '0;
            beat_cnt <= '0;
            instr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ireq.valid) begin
                        if (hit) begin
                            instr <= rd_word;
                            state <= RESP;
                        end else begin
                            req_addr <= ireq.addr;
                            beat_cnt <= '0;
                            state    <= REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (cresp.ready) begin
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                        // a redirected requester gets no answer for this line
                        if (cresp.last) begin
                            if (same_req) begin
                                instr <= refill_word;
                                state <= RESP;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        iresp         = '0;
        iresp.addr_ok = (state == IDLE) && ireq.valid;
        iresp.data_ok = (state == RESP);
        iresp.data    = instr;

        creq = '0;
        if (state == REFILL) begin
            creq.valid    = 1'b1;
            creq.is_write = 1'b0;
            creq.size     = CBUS_SIZE_8B;
            creq.addr     = {req_addr[31:OFF_W], {OFF_W{1'b0}}};
            creq.strobe   = '0;
            creq.len      = cbus_burst_len(LINE_BEATS);
        end
    end

`ifdef ICACHE_PERF_EN
    logic [63:0] hit_cnt;
    logic [63:0] miss_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if ((state == IDLE) && ireq.valid) begin
            if (hit) begin
                hit_cnt <= hit_cnt + 64'd1;
            end else begin
                miss_cnt <= miss_cnt + 64'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && (state == RESP) && (instr == 32'h0005006b)) begin
            $display("icache perf: hit %0d miss %0d", hit_cnt, miss_cnt);
        end
    end
`else
`endif
endmodule

// File: doc/icache_ibus_responder.md
# icache_ibus_responder

Direct-mapped, read-only instruction cache serving the fetch stage as the responder on the ibus handshake: it accepts `ireq`, answers via `iresp`. Hits complete in one cycle. Misses refill a whole line with one burst read on the cache bus (cbus) toward memory, then answer. It sits between fetch and the memory-side interconnect.

## Interface
- `NUM_LINES`, 16: number of lines, power of two.
- `LINE_BEATS`, 2: 64-bit cbus beats per line, power of two. The default line is 16 B.
- `clk`  in  1: clock.
- `reset`  in  1: reset, asynchronous, active-high.
- `ireq`  in  ibus_req_t: `valid`, `addr` (addr_t). The requester holds both stable until it sees `data_ok` or is redirected.
- `iresp`  out  ibus_resp_t: `addr_ok`, `data_ok`, `data` (u32).
- `creq`  out  cbus_req_t: `valid`, `is_write`, `size`, `addr`, `strobe`, `data`, `len`.
- `cresp`  in  cbus_resp_t: `ready`, `last`, `data` (u64).

## Operation
- Address split:
  - offset = `addr[3+$clog2(LINE_BEATS)-1:0]`; beat select = `addr[3+:$clog2(LINE_BEATS)]`; half select = `addr[2]`.
  - index = next `$clog2(NUM_LINES)` bits; tag = remaining upper bits.
  - `addr[1:0]` is ignored.
- Per line: `valid` bit, tag, `LINE_BEATS` x 64-bit data.
- FSM states: IDLE, REFILL, RESP.
- IDLE:
  - `ireq.valid` and hit: register the selected 32-bit instruction, pulse `addr_ok`, go to RESP.
  - `ireq.valid` and miss: capture `req_addr`, pulse `addr_ok`, clear the beat counter, go to REFILL.
  - Otherwise stay in IDLE.
- REFILL:
  - `creq.valid=1`, `is_write=0`, `size`=8 B, `addr`=line-aligned `req_addr`, `len`=`LINE_BEATS` beats, `strobe=0`.
  - Each cycle with `cresp.ready`: write `cresp.data` into beat[counter] of the indexed line, then increment the counter.
  - On `ready & last`: set the line's valid bit and write its tag in the same edge. Then:
    - `ireq.valid` still high and `ireq.addr == req_addr`: latch the instruction from the refilled data (bypass the array for the last beat) and go to RESP.
    - Otherwise (requester was redirected): go to IDLE with no `data_ok`.
  - A refill is never aborted.
- RESP:
  - `data_ok=1` for exactly one cycle, with `data` = the latched instruction; then go to IDLE.
  - `ireq` is not examined in RESP. The requester still shows the old request this cycle.
- `iresp.data` holds its last value outside RESP.
- Replacement: the indexed line is overwritten. There is no write path and no coherence with dbus.

## Timing
- Reset values: all outputs 0, FSM in IDLE, all line valid bits 0, beat counter 0. Data/tag arrays need not be reset.
- Hit latency: request seen in IDLE at cycle N, `data_ok` at N+1. Throughput is one fetch per 2 cycles.
- Miss latency: `creq.valid` from N+1 until the `last` beat at cycle M, `data_ok` at M+1.
- `addr_ok` and `data_ok` are single-cycle pulses, never high in consecutive cycles for the same request.
- `ireq.valid` drops mid-REFILL: the burst completes, the line is installed, and FSM returns to IDLE silently.
- `ireq.valid` returns with a new address during REFILL: it is looked up only once FSM is back in IDLE.
- Async reset mid-REFILL: `creq.valid` drops immediately and FSM goes to IDLE. The partly written line stays invalid, because its valid bit is only set on `last`.
- Beat counter wraps at `LINE_BEATS`. The line is only validated on `last`, not on counter wrap.

## Configuration
- `ICACHE_PERF_EN` defined: two 64-bit counters, `hit_cnt` and `miss_cnt`.
  - Both clear on reset.
  - Each increments once per IDLE acceptance, according to hit or miss.
  - When `data_ok` returns instruction `32'h0005006b`, both counters are `$display`ed.
- Undefined: no counters and no display. Port behaviour is identical in both builds.

## Structure
- `icache_state_t` (IDLE/REFILL/RESP) and the cbus constants (size 8 B, burst length from `LINE_BEATS`) go in the shared `pipes` package.
- `ibus_*` and `cbus_*` types stay in `common`.
- Sub-module `icache_array`:
  - Owns valid/tag/data storage.
  - Inputs: a read index, a write beat port, and a validate strobe that sets the valid bit and writes the tag.
  - Outputs: hit and the selected word.
- The top level holds the FSM, the address capture, and the beat counter.

## Test plan
- Cold fetch at `0x8000_0000`: cbus burst to `0x8000_0000`, 2 beats; `data_ok` one cycle after `last`; `data` = low half of beat 0.
- Fetch `0x8000_0004` after that fill: no `creq.valid`; `data_ok` at N+1; `data` = high half of beat 0.
- `0x8000_0100` then `0x8000_0000` (same index, different tag): both miss; the second refill overwrites the line.
- Drop `ireq.valid` while beat 0 of a refill is in flight: the burst still completes; no `data_ok`; the next request to that line hits.
- Assert `reset` during beat 1: `creq.valid=0` in the same cycle; the following fetch of that line misses.
- With `ICACHE_PERF_EN`: 3 misses, 5 hits, then fetch of `0x0005006b` → display shows hit 6, miss 3, counting the final fetch as a hit.
